// File: rtl/regfile_pkg.sv
// Shared constants and bus-slicing helper for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

  // Widest flattened bus and widest single field the slicing helper handles.
  localparam int MAX_BUS  = 2048;
  localparam int SLICE_W  = 64;

  // Extract field idx of the given width from a flattened, zero-extended port bus.
  function automatic logic [SLICE_W-1:0] slice_bus(input logic [MAX_BUS-1:0] bus,
                                                   input int idx,
                                                   input int width);
    logic [MAX_BUS-1:0] shifted;
    logic [SLICE_W-1:0] mask;
    shifted = bus >> (idx * width);
    if (width >= SLICE_W) begin
      mask = '1;
    end else begin
      mask = (SLICE_W'(1) << width) - SLICE_W'(1);
    end
    return shifted[SLICE_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, flushed as a whole.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int NWP  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NWP-1:0]    i_wen,
  input  logic [NWP*AW-1:0] i_waddr,
  input  logic              i_alloc,
  input  logic [AW-1:0]     i_alloc_rd,
  input  logic              i_flush,
  output logic [NREG-1:0]   o_busy_vec
);

  logic [AW-1:0]   waddr_s [NWP];
  logic [NREG-1:0] clear_s;
  logic [NREG-1:0] set_s;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_q;

  // Unpack write addresses and build the writeback clear mask.
  always_comb begin
    clear_s = '0;
    for (int k = 0; k < NWP; k++) begin
      waddr_s[k] = AW'(slice_bus(MAX_BUS'(i_waddr), k, AW));
      clear_s[waddr_s[k]] = clear_s[waddr_s[k]] | i_wen[k];
    end
  end

  // Build the issue set mask for the destination being allocated.
  always_comb begin
    set_s = '0;
    if (i_alloc) begin
      set_s[i_alloc_rd] = 1'b1;
    end else begin
      set_s = '0;
    end
  end

  // Next busy state: flush wins, then alloc over clear, then hold; x0 never busy.
  always_comb begin
    if (i_flush) begin
      busy_d = '0;
    end else begin
      busy_d = (busy_q & ~clear_s) | set_s;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hardwired x0, optional write->read bypass
// and a RAW busy scoreboard for the ID stage.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int BYPASS = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NWP-1:0]      i_wen,
  input  logic [NWP*AW-1:0]   i_waddr,
  input  logic [NWP*XLEN-1:0] i_wdata,
  input  logic [NRP*AW-1:0]   i_raddr,
  output logic [NRP*XLEN-1:0] o_rdata,
  output logic [NRP-1:0]      o_rbusy,
  input  logic                i_alloc,
  input  logic [AW-1:0]       i_alloc_rd,
  input  logic                i_flush,
  output logic [NREG-1:0]     o_busy_vec,
  output logic                s_a0zero
);

  localparam logic BYP_EN = (BYPASS != 0);

  logic [AW-1:0]   waddr_s  [NWP];
  logic [XLEN-1:0] wdata_s  [NWP];
  logic            wvalid_s [NWP];
  logic [AW-1:0]   raddr_s  [NRP];
  logic [XLEN-1:0] rd_data_s[NRP];
  logic            rd_hit_s [NRP];
  logic [XLEN-1:0] rf_q     [NREG];
  logic [XLEN-1:0] rf_d     [NREG];
  logic [NREG-1:0] sb_busy_s;

  // Unpack port buses; a write is live only when enabled, nonzero and not in reset.
  always_comb begin
    for (int k = 0; k < NWP; k++) begin
      waddr_s[k]  = AW'(slice_bus(MAX_BUS'(i_waddr), k, AW));
      wdata_s[k]  = XLEN'(slice_bus(MAX_BUS'(i_wdata), k, XLEN));
      wvalid_s[k] = i_wen[k] & (waddr_s[k] != AW'(REG_ZERO)) & ~i_rst;
    end
    for (int j = 0; j < NRP; j++) begin
      raddr_s[j] = AW'(slice_bus(MAX_BUS'(i_raddr), j, AW));
    end
  end

  // Next storage state; ascending port order lets the highest index win a collision.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      rf_d[r] = rf_q[r];
    end
    for (int k = 0; k < NWP; k++) begin
      rf_d[waddr_s[k]] = wvalid_s[k] ? wdata_s[k] : rf_d[waddr_s[k]];
    end
    rf_d[REG_ZERO] = '0;
  end

  // Storage array with synchronous clear.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (i_rst) begin
        rf_q[r] <= '0;
      end else begin
        rf_q[r] <= rf_d[r];
      end
    end
  end

  // Read muxes with optional same-cycle forwarding (highest matching write port).
  always_comb begin
    for (int j = 0; j < NRP; j++) begin
      rd_data_s[j] = rf_q[raddr_s[j]];
      rd_hit_s[j]  = 1'b0;
      for (int k = 0; k < NWP; k++) begin
        rd_hit_s[j]  = rd_hit_s[j] | (BYP_EN & wvalid_s[k] & (waddr_s[k] == raddr_s[j]));
        rd_data_s[j] = (BYP_EN & wvalid_s[k] & (waddr_s[k] == raddr_s[j])) ?
                       wdata_s[k] : rd_data_s[j];
      end
    end
  end

  // Drive read outputs; x0 and reset force zero data and no hazard.
  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int j = 0; j < NRP; j++) begin
      if (i_rst || (raddr_s[j] == AW'(REG_ZERO))) begin
        o_rdata[j*XLEN +: XLEN] = '0;
        o_rbusy[j]              = 1'b0;
      end else begin
        o_rdata[j*XLEN +: XLEN] = rd_data_s[j];
        o_rbusy[j]              = sb_busy_s[raddr_s[j]] & ~rd_hit_s[j];
      end
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NWP  (NWP)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wen      (i_wen),
    .i_waddr    (i_waddr),
    .i_alloc    (i_alloc),
    .i_alloc_rd (i_alloc_rd),
    .i_flush    (i_flush),
    .o_busy_vec (sb_busy_s)
  );

  assign o_busy_vec = i_rst ? '0 : sb_busy_s;

`ifndef SYNTHESIS
  assign s_a0zero = i_rst | (rf_q[AW'(REG_A0)] == '0);
`else
  assign s_a0zero = 1'b0;
`endif

endmodule
